// File: rtl/axi_read_arbiter3_if.sv
// -----------------------------------------------------------------------------
// axi_read_arbiter3_if
// Bundles every signal of the three-to-one AXI3 read arbiter: the three
// CPU-side read ports (s_*, packed per slave, slave i in [i*W +: W]) and the
// single read master toward the SoC interconnect (m_*).
//
// Modports
//   master : the arbiter itself. It consumes s_ar*, s_rready and the m_r*
//            response, and drives m_ar*, s_arready, s_rvalid and the
//            broadcast s_r* response.
//   slave  : the surroundings (caches plus interconnect), mirror image.
// -----------------------------------------------------------------------------
interface axi_read_arbiter3_if #(
    parameter int BUS_WIDTH = 4
);
    // CPU-side AR channels, packed per slave
    logic [3*BUS_WIDTH-1:0] s_arid;
    logic [3*32-1:0]        s_araddr;
    logic [3*4-1:0]         s_arlen;
    logic [3*3-1:0]         s_arsize;
    logic [3*2-1:0]         s_arburst;
    logic [3*2-1:0]         s_arlock;
    logic [3*4-1:0]         s_arcache;
    logic [3*3-1:0]         s_arprot;
    logic [2:0]             s_arvalid;
    logic [2:0]             s_arready;
    // CPU-side R channels, payload broadcast, valid/ready per slave
    logic [BUS_WIDTH-1:0]   s_rid;
    logic [31:0]            s_rdata;
    logic [1:0]             s_rresp;
    logic                   s_rlast;
    logic [2:0]             s_rvalid;
    logic [2:0]             s_rready;
    // Interconnect-side AR channel
    logic [BUS_WIDTH-1:0]   m_arid;
    logic [31:0]            m_araddr;
    logic [3:0]             m_arlen;
    logic [2:0]             m_arsize;
    logic [1:0]             m_arburst;
    logic [1:0]             m_arlock;
    logic [3:0]             m_arcache;
    logic [2:0]             m_arprot;
    logic                   m_arvalid;
    logic                   m_arready;
    // Interconnect-side R channel
    logic [BUS_WIDTH-1:0]   m_rid;
    logic [31:0]            m_rdata;
    logic [1:0]             m_rresp;
    logic                   m_rlast;
    logic                   m_rvalid;
    logic                   m_rready;

    modport master (
        input  s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arlock,
               s_arcache, s_arprot, s_arvalid, s_rready,
               m_arready, m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
        output s_arready, s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
               m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arlock,
               m_arcache, m_arprot, m_arvalid, m_rready
    );

    modport slave (
        output s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arlock,
               s_arcache, s_arprot, s_arvalid, s_rready,
               m_arready, m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
        input  s_arready, s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
               m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arlock,
               m_arcache, m_arprot, m_arvalid, m_rready
    );
endinterface

// File: rtl/axi_read_arbiter3.sv
// -----------------------------------------------------------------------------
// axi_read_arbiter3
// Merges the icache (0), dcache (1) and uncached (2) AXI3 read ports of the
// CPU core onto a single AXI3 read master. One burst is outstanding at a time:
// IDLE picks a winner, ADDR presents its AR request until accepted, DATA
// routes R beats to the winner until rlast. Grant is round-robin
// (ROUND_ROBIN=1) or fixed priority with slave 0 highest (ROUND_ROBIN=0).
//
// Ports
//   aclk : clock, rising edge
//   rst  : asynchronous reset, active-high
//   bus  : axi_read_arbiter3_if.master (three CPU read ports + bus master)
// -----------------------------------------------------------------------------
module axi_read_arbiter3 #(
    parameter int BUS_WIDTH   = 4,
    parameter int ROUND_ROBIN = 1
) (
    input  logic                aclk,
    input  logic                rst,
    axi_read_arbiter3_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] grant, grant_nxt;
    logic [1:0] last_grant, last_grant_nxt;
    logic [1:0] winner;
    logic [1:0] first, second, third;

    // Scan order for the next grant. Round-robin starts just after the last
    // slave served; fixed priority always scans 0,1,2. last_grant resets to 2
    // so the very first round-robin scan is also 0,1,2.
    always_comb begin
        first  = 2'd0;
        second = 2'd1;
        third  = 2'd2;
        if (ROUND_ROBIN != 0) begin
            case (last_grant)
                2'd0:    begin first = 2'd1; second = 2'd2; third = 2'd0; end
                2'd1:    begin first = 2'd2; second = 2'd0; third = 2'd1; end
                default: begin first = 2'd0; second = 2'd1; third = 2'd2; end
            endcase
        end
        // 'third' may not be requesting; winner is only used when some slave is.
        if (bus.s_arvalid[first])       winner = first;
        else if (bus.s_arvalid[second]) winner = second;
        else                            winner = third;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of the others, independent of statement order.
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= 2'd0;
            last_grant <= 2'd2;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // R payload is a pure pass-through; only valid/ready are steered.
    assign bus.s_rid   = bus.m_rid;
    assign bus.s_rdata = bus.m_rdata;
    assign bus.s_rresp = bus.m_rresp;
    assign bus.s_rlast = bus.m_rlast;

    // NOTE: every signal this block writes gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        bus.m_arid     = '0;
        bus.m_araddr   = '0;
        bus.m_arlen    = '0;
        bus.m_arsize   = '0;
        bus.m_arburst  = '0;
        bus.m_arlock   = '0;
        bus.m_arcache  = '0;
        bus.m_arprot   = '0;
        bus.m_arvalid  = 1'b0;
        bus.m_rready   = 1'b0;
        bus.s_arready  = '0;
        bus.s_rvalid   = '0;

        case (state)
            IDLE: begin
                if (|bus.s_arvalid) begin
                    grant_nxt = winner;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                // Fields follow the granted slave live; grant is frozen here.
                bus.m_arid    = bus.s_arid[grant*BUS_WIDTH +: BUS_WIDTH];
                bus.m_araddr  = bus.s_araddr[grant*32 +: 32];
                bus.m_arlen   = bus.s_arlen[grant*4 +: 4];
                bus.m_arsize  = bus.s_arsize[grant*3 +: 3];
                bus.m_arburst = bus.s_arburst[grant*2 +: 2];
                bus.m_arlock  = bus.s_arlock[grant*2 +: 2];
                bus.m_arcache = bus.s_arcache[grant*4 +: 4];
                bus.m_arprot  = bus.s_arprot[grant*3 +: 3];
                bus.m_arvalid = 1'b1;
                bus.s_arready[grant] = bus.m_arready;
                if (bus.m_arready) begin
                    last_grant_nxt = grant;
                    state_nxt      = DATA;
                end
            end
            DATA: begin
                bus.s_rvalid[grant] = bus.m_rvalid;
                bus.m_rready        = bus.s_rready[grant];
                // Error responses do not end the burst; only rlast does.
                if (bus.m_rvalid && bus.s_rready[grant] && bus.m_rlast) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_read_arbiter3.sv
// -----------------------------------------------------------------------------
// tb_axi_read_arbiter3
// Drives the three CPU read ports and the interconnect side of the arbiter
// with randomized requests, AR back-pressure and R beats, and predicts every
// output from a small model: which slave wins (modulo-3 scan after the last
// grant, or lowest index), which fields must appear on m_ar*, and which data
// sequence the winner must receive. A second instance with fixed priority
// shares the inputs during a lockstep phase.
// -----------------------------------------------------------------------------
module tb_axi_read_arbiter3;

    localparam int BW = 4;

    typedef struct packed {
        logic [BW-1:0] id;
        logic [31:0]   addr;
        logic [3:0]    len;
        logic [2:0]    size;
        logic [1:0]    burst;
        logic [1:0]    lock;
        logic [3:0]    cache;
        logic [2:0]    prot;
    } ar_t;

    logic aclk = 1'b0;
    logic rst  = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    ar_t        req_f [3];
    logic [2:0] req_mask   = 3'b000;
    int         last_grant = 2;

    axi_read_arbiter3_if #(.BUS_WIDTH(BW)) bus ();
    axi_read_arbiter3_if #(.BUS_WIDTH(BW)) bus_fp ();

    axi_read_arbiter3 #(.BUS_WIDTH(BW), .ROUND_ROBIN(1)) dut (
        .aclk (aclk),
        .rst  (rst),
        .bus  (bus)
    );

    axi_read_arbiter3 #(.BUS_WIDTH(BW), .ROUND_ROBIN(0)) dut_fp (
        .aclk (aclk),
        .rst  (rst),
        .bus  (bus_fp)
    );

    // Fixed-priority instance sees exactly the same inputs.
    assign bus_fp.s_arid    = bus.s_arid;
    assign bus_fp.s_araddr  = bus.s_araddr;
    assign bus_fp.s_arlen   = bus.s_arlen;
    assign bus_fp.s_arsize  = bus.s_arsize;
    assign bus_fp.s_arburst = bus.s_arburst;
    assign bus_fp.s_arlock  = bus.s_arlock;
    assign bus_fp.s_arcache = bus.s_arcache;
    assign bus_fp.s_arprot  = bus.s_arprot;
    assign bus_fp.s_arvalid = bus.s_arvalid;
    assign bus_fp.s_rready  = bus.s_rready;
    assign bus_fp.m_arready = bus.m_arready;
    assign bus_fp.m_rid     = bus.m_rid;
    assign bus_fp.m_rdata   = bus.m_rdata;
    assign bus_fp.m_rresp   = bus.m_rresp;
    assign bus_fp.m_rlast   = bus.m_rlast;
    assign bus_fp.m_rvalid  = bus.m_rvalid;

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Reference arbitration rule straight from the grant policy.
    function automatic int model_winner(input logic [2:0] m, input int last, input bit rr);
        if (rr) begin
            for (int k = 1; k <= 3; k++) if (m[(last + k) % 3]) return (last + k) % 3;
        end else begin
            for (int i = 0; i < 3; i++) if (m[i]) return i;
        end
        return 0;
    endfunction

    task automatic drive_req();
        for (int i = 0; i < 3; i++) begin
            bus.s_arid[i*BW +: BW]  = req_f[i].id;
            bus.s_araddr[i*32 +: 32] = req_f[i].addr;
            bus.s_arlen[i*4 +: 4]    = req_f[i].len;
            bus.s_arsize[i*3 +: 3]   = req_f[i].size;
            bus.s_arburst[i*2 +: 2]  = req_f[i].burst;
            bus.s_arlock[i*2 +: 2]   = req_f[i].lock;
            bus.s_arcache[i*4 +: 4]  = req_f[i].cache;
            bus.s_arprot[i*3 +: 3]   = req_f[i].prot;
        end
        bus.s_arvalid = req_mask;
    endtask

    task automatic new_req(input int i);
        req_f[i] = ar_t'({$urandom, $urandom});
        req_mask[i] = 1'b1;
    endtask

    task automatic check_idle();
        @(negedge aclk);
        check("idle_arvalid", bus.m_arvalid, 0);
        check("idle_arready", bus.s_arready, 0);
        check("idle_rvalid",  bus.s_rvalid, 0);
        check("idle_rready",  bus.m_rready, 0);
        check("idle_araddr",  bus.m_araddr, 0);
        check("idle_arid",    bus.m_arid, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_mask = 3'b000;
        bus.s_arvalid = 3'b111;
        bus.m_arready = 1'b1;
        bus.m_rvalid  = 1'b1;
        bus.m_rlast   = 1'b1;
        bus.s_rready  = 3'b111;
        tick();
        @(negedge aclk);
        check("rst_arvalid", bus.m_arvalid, 0);
        check("rst_arready", bus.s_arready, 0);
        check("rst_rvalid",  bus.s_rvalid, 0);
        check("rst_rready",  bus.m_rready, 0);
        check("rst_araddr",  bus.m_araddr, 0);
        check("rst_arlen",   bus.m_arlen, 0);
        tick();
        rst = 1'b0;
        drive_req();
        bus.m_arready = 1'b0;
        bus.m_rvalid  = 1'b0;
        bus.s_rready  = 3'b000;
        last_grant = 2;
    endtask

    // One arbitration + burst. Entered in IDLE with req_mask already set.
    // rmode: 0 random beats, 1 always valid/ready, 2 granted rready toggling
    // 1,0,1,.. with data 0.., 3 SLVERR on beat 2.
    task automatic run_txn(input int ar_delay, input int rmode, input bit chk_fp);
        int          w, w_fp, nbeats, beat, cyc;
        logic [31:0] base;
        logic [2:0]  rr;
        logic        vld;
        logic [1:0]  resp;
        logic [BW-1:0] rid;
        logic [53:0] obs;
        logic [31:0] got_q[$];

        drive_req();
        // Garbage on the R side must not leak while idle.
        bus.m_rvalid  = 1'b1;
        bus.m_rlast   = 1'b1;
        bus.s_rready  = 3'b111;
        bus.m_arready = 1'($urandom);
        check_idle();
        w    = model_winner(req_mask, last_grant, 1'b1);
        w_fp = model_winner(req_mask, 0, 1'b0);
        tick();
        bus.m_rvalid = 1'b0;

        for (int c = 0; c <= ar_delay; c++) begin
            bus.m_arready = (c == ar_delay);
            if (c < ar_delay && $urandom_range(0, 3) == 0) begin
                int i;
                i = $urandom_range(0, 2);
                if (i != w) req_mask[i] = 1'b0;
                drive_req();
            end
            @(negedge aclk);
            obs = {bus.m_arid, bus.m_araddr, bus.m_arlen, bus.m_arsize,
                   bus.m_arburst, bus.m_arlock, bus.m_arcache, bus.m_arprot};
            check("ar_valid",  bus.m_arvalid, 1);
            check("ar_fields", obs, req_f[w]);
            check("ar_sready", bus.s_arready, (c == ar_delay) ? (3'b001 << w) : 3'b000);
            if (chk_fp && c == 0) begin
                check("fp_arvalid", bus_fp.m_arvalid, 1);
                check("fp_araddr",  bus_fp.m_araddr, req_f[w_fp].addr);
            end
            tick();
        end
        last_grant = w;
        req_mask[w] = 1'b0;
        drive_req();
        bus.m_arready = 1'b0;

        nbeats = int'(req_f[w].len) + 1;
        base   = (rmode == 2) ? 32'd0 : $urandom;
        beat   = 0;
        cyc    = 0;
        while (beat < nbeats && cyc < 400) begin
            vld = (rmode == 1 || rmode == 2) ? 1'b1 : ($urandom_range(0, 9) < 7);
            rr  = (rmode == 1) ? 3'b111 : 3'($urandom);
            if (rmode == 2) rr[w] = (cyc % 2 == 0);
            resp = (rmode == 3) ? ((beat == 2) ? 2'b10 : 2'b00) : 2'($urandom);
            rid  = BW'($urandom);
            bus.m_rvalid = vld;
            bus.m_rdata  = base + 32'(beat);
            bus.m_rlast  = (beat == nbeats - 1);
            bus.m_rresp  = resp;
            bus.m_rid    = rid;
            bus.s_rready = rr;
            @(negedge aclk);
            check("r_svalid",  bus.s_rvalid, vld ? (3'b001 << w) : 3'b000);
            check("r_mready",  bus.m_rready, rr[w]);
            check("r_data",    bus.s_rdata, base + 32'(beat));
            check("r_resp",    bus.s_rresp, resp);
            check("r_last",    bus.s_rlast, (beat == nbeats - 1));
            check("r_id",      bus.s_rid, rid);
            check("r_arvalid", bus.m_arvalid, 0);
            check("r_araddr",  bus.m_araddr, 0);
            if (bus.s_rvalid[w] && bus.s_rready[w]) got_q.push_back(bus.s_rdata);
            if (vld && rr[w]) beat++;
            tick();
            cyc++;
        end
        if (beat < nbeats) check("burst_timeout", beat, nbeats);
        check("beat_count", got_q.size(), nbeats);
        foreach (got_q[k]) check("beat_seq", got_q[k], base + 32'(k));
        bus.m_rvalid = 1'b0;
    endtask

    initial begin
        bus.s_arid = '0; bus.s_araddr = '0; bus.s_arlen = '0; bus.s_arsize = '0;
        bus.s_arburst = '0; bus.s_arlock = '0; bus.s_arcache = '0; bus.s_arprot = '0;
        bus.s_arvalid = '0; bus.s_rready = '0; bus.m_arready = 1'b0;
        bus.m_rid = '0; bus.m_rdata = '0; bus.m_rresp = '0; bus.m_rlast = 1'b0;
        bus.m_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) req_f[i] = '0;

        // Single request from slave 1, 8-beat burst.
        do_reset();
        new_req(1);
        req_f[1].addr = 32'h1FC0_0000;
        req_f[1].len  = 4'd7;
        run_txn(0, 1, 1'b0);

        // All three held: round-robin 0,1,2,0 and fixed priority always 0.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            new_req(i);
            req_f[i].addr = 32'h1000_0000 * (i + 1);
            req_f[i].len  = 4'(i);
        end
        repeat (4) begin
            req_mask = 3'b111;
            run_txn(0, 1, 1'b1);
        end

        // AR back-pressure for 5 cycles.
        req_mask = 3'b000;
        new_req(2);
        run_txn(5, 0, 1'b0);

        // Granted rready toggling, data 0..3.
        new_req(0);
        req_f[0].len = 4'd3;
        run_txn(1, 2, 1'b0);

        // SLVERR on beat 2 of 4.
        new_req(1);
        req_f[1].len = 4'd3;
        run_txn(0, 3, 1'b0);

        // Randomized traffic.
        repeat (30) begin
            for (int i = 0; i < 3; i++)
                if (!req_mask[i] && $urandom_range(0, 2) == 0) new_req(i);
            if (req_mask == 3'b000) new_req($urandom_range(0, 2));
            run_txn($urandom_range(0, 3), 0, 1'b0);
        end
        req_mask = 3'b000;
        drive_req();
        bus.m_rvalid = 1'b1;
        check_idle();
        tick();

        // Reset during beat 3 of an 8-beat burst.
        do_reset();
        new_req(2);
        req_f[2].len = 4'd7;
        drive_req();
        tick();
        bus.m_arready = 1'b1;
        tick();
        bus.m_arready = 1'b0;
        req_mask = 3'b000;
        drive_req();
        bus.m_rvalid = 1'b1;
        bus.m_rlast  = 1'b0;
        bus.s_rready = 3'b111;
        repeat (2) tick();
        @(negedge aclk);
        check("pre_rst_rvalid", bus.s_rvalid, 3'b100);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_rready",  bus.m_rready, 0);
        check("mid_rst_rvalid",  bus.s_rvalid, 0);
        check("mid_rst_arvalid", bus.m_arvalid, 0);
        tick();
        rst = 1'b0;
        bus.m_rvalid = 1'b0;
        bus.s_rready = 3'b000;
        last_grant = 2;
        new_req(1);
        run_txn(1, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
